// File: rtl/counter_bank_pkg.sv
// rtl/counter_bank_pkg.sv - shared types and next-count helper for the counter bank
package counter_bank_pkg;

  // Widest channel the shared helper can evaluate; channels zero-extend into it.
  localparam int unsigned CNT_MAX_W = 32;
  localparam logic [CNT_MAX_W-1:0] CNT_ONE = CNT_MAX_W'(1);

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef struct packed {
    logic [CNT_MAX_W-1:0] value;
    logic                 term;
  } cnt_next_t;

  // Value a channel moves to when it steps, plus whether it sits at terminal.
  // Up counts treat anything at or above the limit as terminal so a lowered
  // limit never lets the counter run away.
  function automatic cnt_next_t next_count(input logic [CNT_MAX_W-1:0] count,
                                           input logic [CNT_MAX_W-1:0] limit,
                                           input logic                 up,
                                           input cnt_mode_e            mode);
    cnt_next_t r;
    r.term = up ? (count >= limit) : (count == '0);
    if (r.term) begin
      if (mode == CNT_SAT) begin
        r.value = count;
      end else begin
        r.value = up ? '0 : limit;
      end
    end else begin
      r.value = up ? (count + CNT_ONE) : (count - CNT_ONE);
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// rtl/counter_channel.sv - one counter channel with load, limit, wrap/saturate and tc
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             up_dn_i,
  input  cnt_mode_e        mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             term_evt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0]     count_q, count_d;
  logic                 tc_q, tc_d;
  logic [CNT_MAX_W-1:0] count_ext, limit_ext;
  cnt_next_t            nxt;

  // Widen count and limit so the shared helper can evaluate them.
  always_comb begin
    count_ext = '0;
    limit_ext = '0;
    count_ext[WIDTH-1:0] = count_q;
    limit_ext[WIDTH-1:0] = limit_i;
  end

  assign nxt = next_count(count_ext, limit_ext, up_dn_i, mode_i);

  // A terminal event needs a real step that is not overridden by load or clear.
  assign term_evt_o = step_i & nxt.term & ~load_i & ~clr_i;

  if (WIDTH < CNT_MAX_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^nxt.value[CNT_MAX_W-1:WIDTH];
  end

  // Next-state priority: clear, load, step, hold.
  always_comb begin
    count_d = count_q;
    tc_d    = term_evt_o;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (step_i) begin
      count_d = nxt.value[WIDTH-1:0];
    end
  end

  // Count and terminal-count pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - multi-channel counter bank with shared prescaler and cascading
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [PRESC_W-1:0]      presc_div,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       up_dn,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       cascade,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH*WIDTH-1:0] limit,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       tc
);

  logic [PRESC_W-1:0] pc_q, pc_d;
  logic               tick;
  logic               unused_cascade0;

  // Channel 0 has no predecessor, so its cascade bit has no meaning.
  assign unused_cascade0 = cascade[0];

  // Compare with >= so lowering presc_div mid-count cannot strand the divider.
  assign tick = (pc_q >= presc_div);

  // Prescaler next state: restart on tick or clear, otherwise advance.
  always_comb begin
    pc_d = pc_q + PRESC_W'(1);
    if (clr || tick) begin
      pc_d = '0;
    end
  end

  // Prescaler phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic step;
    logic term_evt;

    // Step source: prescaler tick, or the previous channel's terminal event
    // in the same cycle so wide cascaded counters ripple with no latency.
    if (i == 0) begin : g_src
      assign step = en[i] & tick;
    end else begin : g_src
      assign step = en[i] & (cascade[i] ? g_ch[i-1].term_evt : tick);
    end

    counter_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr),
      .step_i     (step),
      .load_i     (load[i]),
      .load_val_i (load_val[i*WIDTH +: WIDTH]),
      .limit_i    (limit[i*WIDTH +: WIDTH]),
      .up_dn_i    (up_dn[i]),
      .mode_i     (cnt_mode_e'(mode[i])),
      .count_o    (count[i*WIDTH +: WIDTH]),
      .term_evt_o (term_evt),
      .tc_o       (tc[i])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - directed self-checking bench for counter_bank
module tb_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [3:0]  presc_div;
  logic [3:0]  en, up_dn, mode, cascade, load;
  logic [31:0] load_val, limit;
  logic [31:0] count;
  logic [3:0]  tc;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_bank #(
    .NUM_CH  (4),
    .WIDTH   (8),
    .PRESC_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .presc_div (presc_div),
    .en        (en),
    .up_dn     (up_dn),
    .mode      (mode),
    .cascade   (cascade),
    .load      (load),
    .load_val  (load_val),
    .limit     (limit),
    .count     (count),
    .tc        (tc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; presc_div = 4'd0;
    en = 4'h0; up_dn = 4'h0; mode = 4'h0; cascade = 4'h0; load = 4'h0;
    load_val = 32'h0; limit = 32'hFFFF_FFFF;
    cyc(3);
    chk("reset_count", count, 32'h0);
    chk("reset_tc", {28'h0, tc}, 32'h0);

    // Free-run, all channels up, wrap at FF
    en = 4'hF; up_dn = 4'hF; rst_n = 1'b1;
    cyc(1);   chk("free_1", count, 32'h0101_0101);
    cyc(254); chk("free_255", count, 32'hFFFF_FFFF);
    chk("free_255_tc", {28'h0, tc}, 32'h0);
    cyc(1);   chk("free_256", count, 32'h0);
    chk("free_256_tc", {28'h0, tc}, 32'hF);
    cyc(1);   chk("free_257", count, 32'h0101_0101);
    chk("free_257_tc", {28'h0, tc}, 32'h0);

    // Prescaler divide by 4, ch0 limit 9
    presc_div = 4'd3; en = 4'h1; limit = 32'hFFFF_FF09; clr = 1'b1;
    cyc(1);   chk("presc_clr", count, 32'h0);
    clr = 1'b0;
    cyc(4);   chk("presc_4", count, 32'h1);
    cyc(1);   chk("presc_5", count, 32'h1);
    cyc(31);  chk("presc_36", count, 32'h9);
    cyc(3);   chk("presc_39", count, 32'h9);
    chk("presc_39_tc", {28'h0, tc}, 32'h0);
    cyc(1);   chk("presc_40", count, 32'h0);
    chk("presc_40_tc", {28'h0, tc}, 32'h1);
    cyc(1);   chk("presc_41_tc", {28'h0, tc}, 32'h0);

    // Down / saturate on ch1 after load of 3
    presc_div = 4'd0; en = 4'b0010; up_dn = 4'h0; mode = 4'b0010;
    load = 4'b0010; load_val = 32'h0000_0300;
    cyc(1);   chk("dsat_load", {24'h0, count[15:8]}, 32'h3);
    chk("dsat_load_tc", {28'h0, tc}, 32'h0);
    load = 4'h0;
    cyc(1);   chk("dsat_2", {24'h0, count[15:8]}, 32'h2);
    cyc(1);   chk("dsat_1", {24'h0, count[15:8]}, 32'h1);
    cyc(1);   chk("dsat_0", {24'h0, count[15:8]}, 32'h0);
    chk("dsat_0_tc", {28'h0, tc}, 32'h0);
    cyc(1);   chk("dsat_hold_a", {24'h0, count[15:8]}, 32'h0);
    chk("dsat_hold_a_tc", {28'h0, tc}, 32'h2);
    cyc(1);   chk("dsat_hold_b", {24'h0, count[15:8]}, 32'h0);
    chk("dsat_hold_b_tc", {28'h0, tc}, 32'h2);

    // Cascade ch1 off ch0, both modulo 10
    clr = 1'b1; en = 4'b0011; up_dn = 4'hF; mode = 4'h0; cascade = 4'b0010;
    limit = 32'hFFFF_0909;
    cyc(1);   chk("casc_clr", count, 32'h0);
    clr = 1'b0;
    cyc(9);   chk("casc_9", {16'h0, count[15:0]}, 32'h0009);
    cyc(1);   chk("casc_10", {16'h0, count[15:0]}, 32'h0100);
    chk("casc_10_tc", {28'h0, tc}, 32'h1);
    cyc(1);   chk("casc_11_tc", {28'h0, tc}, 32'h0);
    cyc(88);  chk("casc_99", {16'h0, count[15:0]}, 32'h0909);
    cyc(1);   chk("casc_100", {16'h0, count[15:0]}, 32'h0000);
    chk("casc_100_tc", {28'h0, tc}, 32'h3);

    // Load wins over a terminal step; value above limit accepted
    cyc(9);   chk("prio_pre", {16'h0, count[15:0]}, 32'h0009);
    load = 4'b0001; load_val = 32'h0000_0042;
    cyc(1);   chk("prio_load", {16'h0, count[15:0]}, 32'h0042);
    chk("prio_load_tc", {28'h0, tc}, 32'h0);
    load = 4'h0;
    cyc(1);   chk("prio_over_limit", {16'h0, count[15:0]}, 32'h0100);
    chk("prio_over_limit_tc", {28'h0, tc}, 32'h1);

    // Clear wins over load
    clr = 1'b1; load = 4'b0001;
    cyc(1);   chk("prio_clr_load", count, 32'h0);
    clr = 1'b0; load = 4'h0;

    // Lowering limit below the current count wraps on next step
    cascade = 4'h0; en = 4'b0001;
    cyc(7);   chk("lim_7", count, 32'h7);
    limit = 32'hFFFF_FF05;
    cyc(1);   chk("lim_wrap", count, 32'h0);
    chk("lim_wrap_tc", {28'h0, tc}, 32'h1);

    // Asynchronous reset mid-run, prescaler phase restarts
    en = 4'hF; up_dn = 4'hF; mode = 4'h0; limit = 32'hFFFF_FFFF;
    cyc(3);   chk("arst_pre", count, 32'h0303_0303);
    presc_div = 4'd2;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 32'h0);
    chk("arst_tc", {28'h0, tc}, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    chk("arst_held", count, 32'h0);
    cyc(2);   chk("arst_r2", count, 32'h0);
    cyc(1);   chk("arst_r3", count, 32'h0101_0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Parametrised multi-channel successor to the single fixed 8-bit free-running counter: NUM_CH independent counters of WIDTH bits.
- Shared clock prescaler drives all channels.
- Per-channel enable, direction, programmable terminal limit, wrap/saturate mode, synchronous load and terminal-count pulse.
- Channel i can cascade off channel i-1's terminal event to form wider counters. Sits in the timer/event-counting layer under a control-register block.

Parameters:
- NUM_CH, 4, number of counter channels (>=1)
- WIDTH, 8, bits per channel counter
- PRESC_W, 4, prescaler divide field width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of all counters, tc and prescaler
- presc_div  in  PRESC_W  tick every presc_div+1 cycles
- en  in  NUM_CH  per-channel count enable
- up_dn  in  NUM_CH  1 = count up, 0 = count down
- mode  in  NUM_CH  0 = WRAP, 1 = SAT
- cascade  in  NUM_CH  1 = channel steps on channel i-1 terminal event; bit 0 ignored
- load  in  NUM_CH  synchronous load strobe
- load_val  in  NUM_CH*WIDTH  load values, channel i at [i*WIDTH +: WIDTH]
- limit  in  NUM_CH*WIDTH  terminal value per channel, same packing
- count  out  NUM_CH*WIDTH  current counts, same packing
- tc  out  NUM_CH  registered one-cycle terminal-count pulse

Behaviour:
- Reset: rst_n low asynchronously sets all count to 0, tc to 0 and the prescaler counter to 0. Release is synchronous to clk.
- Prescaler counter pc:
  - When pc >= presc_div, tick = 1 and pc <= 0; otherwise pc <= pc+1.
  - presc_div = 0 gives a tick every cycle.
  - Lowering presc_div mid-count takes effect on the next compare (>=, no lockup).
- Step source: step[i] = en[i] & (cascade[i] && i>0 ? term_evt[i-1] : tick).
  - term_evt is combinational in the same cycle, so a cascade ripples with zero latency.
  - Channel i-1 must itself step for its term_evt to fire.
- Terminal condition:
  - Up: count >= limit. This covers count > limit after limit is lowered.
  - Down: count == 0.
  - term_evt[i] = step[i] & at_terminal[i] & ~load[i] & ~clr.
- Next-state priority per channel:
  1. clr: count <= 0.
  2. load: count <= load_val; no tc; load_val > limit is accepted as-is.
  3. step at terminal, WRAP: up -> 0, down -> limit.
  4. step at terminal, SAT: count holds.
  5. step otherwise: count ±1 modulo 2^WIDTH.
  6. Otherwise hold.
- tc[i] <= term_evt[i]. It appears one cycle after the terminal step. In SAT mode it pulses on every step taken while held at terminal.
- limit = 0, up, WRAP: channel stays at 0 and pulses tc on every step.
- Direction, mode or limit changes take effect on the next step with no pipeline. clr has priority over everything except rst_n.
- Latency: count updates one cycle after step; no other pipelining.

Decomposition:
- Package counter_bank_pkg: typedef cnt_mode_e {CNT_WRAP=1'b0, CNT_SAT=1'b1}, and a function next_count(count, limit, up, mode) returning the next value and the terminal flag.
- Sub-module counter_channel: one WIDTH-bit channel with inputs step, load, load_val, limit, up_dn, mode, clr, and outputs count, term_evt (combinational) and tc (registered).
- counter_bank instantiates NUM_CH channels in a generate loop plus the prescaler and cascade muxing.

Test Plan:
- Reset/free-run: rst_n low then high, presc_div=0, en=4'hF, up, WRAP, limit=8'hFF → counts 0,1,2…; after 256 steps count = 0 and tc pulses once per channel, one cycle after the FF→0 step.
- Prescaler: presc_div=3, ch0 up, limit=9 → ch0 increments every 4th cycle; reaches 9 at cycle 36, wraps to 0 at cycle 40, tc pulses at cycle 41.
- Down/SAT: ch1 load_val=3, load, then down, SAT → 3,2,1,0,0,0; tc pulses on each step taken at 0; count never underflows to FF.
- Cascade: ch0 limit=9, ch1 cascade=1 limit=9, presc_div=0 → ch1 increments once per 10 cycles; after 100 steps both are 0 and ch1 tc pulses once.
- Priority: load and a terminal step in the same cycle → count = load_val, no tc. clr and load in the same cycle → count = 0. Lowering limit to 5 while count = 7 (up, WRAP) → next step wraps to 0 with tc.
- Async reset mid-run: assert rst_n between clock edges while counts ≠ 0 → count and tc are 0 immediately without a clk edge; after release, counting resumes from 0 with prescaler phase restarted.
